// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, single-outstanding imem port and a small
// decode buffer. Optional misaligned-redirect trap under `MISALIGN_TRAP_EN`.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int unsigned AW       = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(BUF_DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
`ifdef MISALIGN_TRAP_EN
    localparam logic [2:0] HALT  = 3'd4;
`endif

    logic [2:0]    state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   req_pc;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   last_instr, last_pc;
    logic          full, empty, grant, push, pop, redirect;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    // In REQ nothing is in flight, so the free-slot credit reduces to "not full".
    assign imem_req  = (state == REQ) && !full;
    assign imem_addr = {fetch_pc[31:2], 2'b00};
    assign grant     = imem_req && imem_gnt;
    assign pop       = id_valid && id_ready;

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (PCTarget[1:0] != 2'b00);
    assign redirect = PCSrc && (state != HALT);
`else
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^PCTarget[1:0];
    assign redirect        = PCSrc;
`endif

    // A response landing in the same cycle as a redirect is simply dropped.
    assign push = (state == WAIT) && imem_rvalid && !redirect;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (grant) begin
                    state_nxt    = WAIT;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                end
            end
            WAIT, FLUSH: begin
                if (imem_rvalid) state_nxt = REQ;
            end
`ifdef MISALIGN_TRAP_EN
            HALT: state_nxt = HALT;
`endif
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_nxt = {PCTarget[31:2], 2'b00};
            // Only go to FLUSH if a response is still owed after this edge.
            if (grant || (((state == WAIT) || (state == FLUSH)) && !imem_rvalid))
                state_nxt = FLUSH;
            else
                state_nxt = REQ;
`ifdef MISALIGN_TRAP_EN
            if (misalign) state_nxt = HALT;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (grant) req_pc <= imem_addr;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        misalign_err <= 1'b0;
        else if (redirect && misalign)  misalign_err <= 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_instr <= NOP;
            last_pc    <= RESET_PC;
        end else begin
            if (pop) begin
                last_instr <= buf_instr[rd_ptr];
                last_pc    <= buf_pc[rd_ptr];
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

    // When empty the outputs hold the last consumed entry.
    assign id_valid = !empty;
    assign instr    = empty ? last_instr : buf_instr[rd_ptr];
    assign pc       = empty ? last_pc    : buf_pc[rd_ptr];
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[30];
    assign pc_plus4 = pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory responder, stream model of the
// architectural instruction sequence, directed phases then random traffic.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    instr_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .id_ready(id_ready),
        .id_valid(id_valid), .instr(instr), .op(op), .funct3(funct3),
        .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4)
`ifdef MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pops   = 0;

    // memory configuration, written by the stimulus process
    bit gnt_always = 1'b1;
    int lat_fix    = 1;
    bit stray      = 1'b0;

    logic [31:0] redir_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Instruction memory: single outstanding request, latency 1..3 cycles.
    initial begin : memory
        logic [31:0] paddr;
        bit pending;
        int lat;
        pending = 1'b0; lat = 0; paddr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (rst) pending = 1'b0;
            else if (pending) begin
                lat--;
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pending     = 1'b0;
                end
            end
            if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                stray       = 1'b0;
            end
            imem_gnt = imem_req && !pending && (gnt_always || ($urandom_range(0, 2) != 0));
            @(negedge clk);
            if (!rst) begin
                if (pending) check("one_outstanding", {31'b0, imem_req}, 32'd0);
                if (imem_req && imem_gnt) begin
                    check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                    pending = 1'b1;
                    paddr   = imem_addr;
                    lat     = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
                end
            end
        end
    end

    // Monitor: every consumed instruction must be the next one of the
    // architectural stream; a redirect restarts the stream at its target.
    initial begin : monitor
        logic [31:0] exp_pc, exp_instr, t;
        exp_pc = RESET_PC;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = RESET_PC;
                redir_q.delete();
            end else begin
                if (id_valid && id_ready) begin
                    exp_instr = mem_word(exp_pc);
                    check("pop_pc", pc, exp_pc);
                    check("pop_instr", instr, exp_instr);
                    check("pop_op", {25'b0, op}, {25'b0, exp_instr[6:0]});
                    check("pop_funct3", {29'b0, funct3}, {29'b0, exp_instr[14:12]});
                    check("pop_funct7", {31'b0, funct7}, {31'b0, exp_instr[30]});
                    check("pop_pc_plus4", pc_plus4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                if (PCSrc) begin
                    if (redir_q.size() == 0) timeout("redir_queue_empty");
                    else begin
                        t      = redir_q.pop_front();
                        exp_pc = {t[31:2], 2'b00};
                    end
                end
            end
        end
    end

    task automatic redir(input logic [31:0] t);
        @(posedge clk); #1;
        PCSrc = 1'b1; PCTarget = t; redir_q.push_back(t);
        @(posedge clk); #1;
        PCSrc = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) return;
        end
        timeout(name);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (id_valid) return;
        end
        timeout(name);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req) return;
        end
        timeout(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] t;
        rst = 1'b1; PCSrc = 1'b0; PCTarget = '0; id_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, RESET_PC);
        check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);

        // release, latency 1, decode stalled from the start
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        repeat (6) @(negedge clk);
        check("bp_valid", {31'b0, id_valid}, 32'd1);
        check("bp_req_low", {31'b0, imem_req}, 32'd0);
        check("bp_head_pc", pc, RESET_PC);
        @(negedge clk);
        check("bp_req_still_low", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1 id_ready = 1'b1;
        repeat (20) @(negedge clk);

        // redirect while a slow response is outstanding
        lat_fix = 3;
        wait_grant("redir_wait_grant");
        redir(32'h0000_0100);
        wait_req("redir_wait_req");
        check("redir_addr", imem_addr, 32'h0000_0100);
        wait_valid("redir_wait_valid");
        check("redir_head_pc", pc, 32'h0000_0100);
        lat_fix = 1;
        repeat (6) @(negedge clk);

        // wrap-around of the PC
        redir(32'hFFFF_FFFC);
        wait_valid("wrap_wait_valid");
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0000_0000);
        repeat (8) @(negedge clk);

        // misaligned redirect
        redir(32'h0000_0102);
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        check("trap_err", {31'b0, misalign_err}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("trap_no_req", {31'b0, imem_req}, 32'd0);
            check("trap_no_valid", {31'b0, id_valid}, 32'd0);
        end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("trap_err_cleared", {31'b0, misalign_err}, 32'd0);
`else
        wait_valid("mask_wait_valid");
        check("misalign_mask", pc, 32'h0000_0100);
`endif
        repeat (6) @(negedge clk);

        // async reset in WAIT, late response right after release
        lat_fix = 3;
        wait_grant("rst_wait_grant");
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0; stray = 1'b1;
        @(negedge clk);
        check("rstmid_valid0", {31'b0, id_valid}, 32'd0);
        check("rstmid_instr", instr, 32'h0000_0013);
        check("rstmid_pc", pc, RESET_PC);
        @(negedge clk);
        check("rstmid_valid1", {31'b0, id_valid}, 32'd0);
        wait_valid("rstmid_wait_valid");
        check("rstmid_first_pc", pc, RESET_PC);
        check("rstmid_first_instr", instr, 32'h0000_0013);

        // random traffic
        gnt_always = 1'b0; lat_fix = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
                else                           t = $urandom_range(0, 255) << 2;
`ifndef MISALIGN_TRAP_EN
                t = t | 32'($urandom_range(0, 3));
`endif
                PCSrc = 1'b1; PCTarget = t; redir_q.push_back(t);
            end else begin
                PCSrc = 1'b0; PCTarget = $urandom;
            end
        end
        @(posedge clk); #1 PCSrc = 1'b0; id_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("liveness", {31'b0, pops >= 60}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
